// File: rtl/rx_pkg.sv
// Shared definitions for the receive-side frame controller.
package rx_pkg;

  // Frame controller states
  typedef enum logic [2:0] {
    ST_IDLE,
    ST_LEN,
    ST_PAYLOAD,
    ST_CHK,
    ST_HOLD
  } rx_state_e;

  // Error codes reported alongside err_pulse
  localparam logic [1:0] ERR_NONE = 2'b00;
  localparam logic [1:0] ERR_LEN  = 2'b01;
  localparam logic [1:0] ERR_CHK  = 2'b10;
  localparam logic [1:0] ERR_TMO  = 2'b11;

  // Default frame start byte
  localparam logic [7:0] SYNC_DEFAULT = 8'hA5;

endpackage

// File: rtl/frame_buf.sv
// Payload buffer: DEPTH x 8 register array, synchronous write, asynchronous read.
// Deliberately has no reset; contents are only meaningful while a frame is held.
module frame_buf #(
  parameter int DEPTH = 16,
  localparam int AW = $clog2(DEPTH)
) (
  input  logic          clk,
  input  logic          we,
  input  logic [AW-1:0] waddr,
  input  logic [7:0]    wdata,
  input  logic [AW-1:0] raddr,
  output logic [7:0]    rdata
);

  logic [7:0] mem_q [DEPTH];

  // Store one payload byte per write strobe
  always_ff @(posedge clk) begin
    if (we) begin
      mem_q[waddr] <= wdata;
    end
  end

  assign rdata = mem_q[raddr];

endmodule

// File: rtl/rx_frame_ctrl.sv
// Frame controller: hunts for SYNC, collects length, payload and XOR checksum,
// then holds the checked payload until the consumer accepts it.
module rx_frame_ctrl
  import rx_pkg::*;
#(
  parameter int         MAX_LEN = 16,
  parameter logic [7:0] SYNC    = SYNC_DEFAULT,
  parameter int         TIMEOUT = 1023,
  localparam int AW = $clog2(MAX_LEN),
  localparam int LW = AW + 1
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          byte_valid,
  input  logic [7:0]    byte_data,
  output logic          frame_valid,
  input  logic          frame_ready,
  output logic [LW-1:0] frame_len,
  input  logic [AW-1:0] rd_addr,
  output logic [7:0]    rd_data,
  output logic          err_pulse,
  output logic [1:0]    err_code,
  output logic          overrun
);

  localparam int CW = $clog2(TIMEOUT + 1);

  localparam logic [8:0]    MAX_LEN_B = 9'(MAX_LEN);
  localparam logic [AW-1:0] IDX_ONE   = AW'(1);
  localparam logic [LW-1:0] LEN_ONE   = LW'(1);
  localparam logic [CW-1:0] CNT_ONE   = CW'(1);
  localparam logic [CW-1:0] TMO_LAST  = CW'(TIMEOUT - 1);

  rx_state_e     state_q, state_d;
  logic [LW-1:0] len_q, len_d;
  logic [AW-1:0] idx_q, idx_d;
  logic [7:0]    acc_q, acc_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic          err_pulse_q, err_pulse_d;
  logic [1:0]    err_code_q, err_code_d;
  logic          overrun_q, overrun_d;
  logic          frame_valid_q, frame_valid_d;
  logic          buf_we;
  logic          accept;
  logic          tmo_hit;
  logic          last_byte;

  assign accept    = frame_valid_q & frame_ready;
  assign tmo_hit   = (cnt_q == TMO_LAST);
  assign last_byte = ({1'b0, idx_q} == (len_q - LEN_ONE));

  frame_buf #(.DEPTH(MAX_LEN)) u_buf (
    .clk   (clk),
    .we    (buf_we),
    .waddr (idx_q),
    .wdata (byte_data),
    .raddr (rd_addr),
    .rdata (rd_data)
  );

  // Next-state, datapath and error/flag logic for the frame FSM
  always_comb begin
    state_d       = state_q;
    len_d         = len_q;
    idx_d         = idx_q;
    acc_d         = acc_q;
    cnt_d         = '0;
    err_pulse_d   = 1'b0;
    err_code_d    = ERR_NONE;
    overrun_d     = overrun_q;
    frame_valid_d = 1'b0;
    buf_we        = 1'b0;

    case (state_q)
      ST_IDLE: begin
        if (byte_valid && (byte_data == SYNC)) begin
          state_d = ST_LEN;
        end
      end

      ST_LEN: begin
        if (byte_valid) begin
          if ({1'b0, byte_data} > MAX_LEN_B) begin
            err_pulse_d = 1'b1;
            err_code_d  = ERR_LEN;
            state_d     = ST_IDLE;
          end else begin
            len_d   = LW'(byte_data);
            acc_d   = byte_data;
            idx_d   = '0;
            state_d = (byte_data == 8'h00) ? ST_CHK : ST_PAYLOAD;
          end
        end else if (tmo_hit) begin
          err_pulse_d = 1'b1;
          err_code_d  = ERR_TMO;
          state_d     = ST_IDLE;
        end else begin
          cnt_d = cnt_q + CNT_ONE;
        end
      end

      ST_PAYLOAD: begin
        if (byte_valid) begin
          buf_we = 1'b1;
          acc_d  = acc_q ^ byte_data;
          idx_d  = idx_q + IDX_ONE;
          if (last_byte) begin
            state_d = ST_CHK;
          end
        end else if (tmo_hit) begin
          err_pulse_d = 1'b1;
          err_code_d  = ERR_TMO;
          state_d     = ST_IDLE;
        end else begin
          cnt_d = cnt_q + CNT_ONE;
        end
      end

      ST_CHK: begin
        if (byte_valid) begin
          if (byte_data == acc_q) begin
            state_d = ST_HOLD;
          end else begin
            err_pulse_d = 1'b1;
            err_code_d  = ERR_CHK;
            state_d     = ST_IDLE;
          end
        end else if (tmo_hit) begin
          err_pulse_d = 1'b1;
          err_code_d  = ERR_TMO;
          state_d     = ST_IDLE;
        end else begin
          cnt_d = cnt_q + CNT_ONE;
        end
      end

      ST_HOLD: begin
        if (accept) begin
          state_d   = ST_IDLE;
          overrun_d = 1'b0;
        end else begin
          frame_valid_d = 1'b1;
          if (byte_valid) begin
            overrun_d = 1'b1;
          end
        end
      end

      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  // State and datapath registers, cleared asynchronously by rst
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q       <= ST_IDLE;
      len_q         <= '0;
      idx_q         <= '0;
      acc_q         <= '0;
      cnt_q         <= '0;
      err_pulse_q   <= 1'b0;
      err_code_q    <= ERR_NONE;
      overrun_q     <= 1'b0;
      frame_valid_q <= 1'b0;
    end else begin
      state_q       <= state_d;
      len_q         <= len_d;
      idx_q         <= idx_d;
      acc_q         <= acc_d;
      cnt_q         <= cnt_d;
      err_pulse_q   <= err_pulse_d;
      err_code_q    <= err_code_d;
      overrun_q     <= overrun_d;
      frame_valid_q <= frame_valid_d;
    end
  end

  assign frame_valid = frame_valid_q;
  assign frame_len   = len_q;
  assign err_pulse   = err_pulse_q;
  assign err_code    = err_code_q;
  assign overrun     = overrun_q;

endmodule

// File: tb/tb_rx_frame_ctrl.sv
// Directed self-checking bench for rx_frame_ctrl.
module tb_rx_frame_ctrl;

  localparam int MAX_LEN = 16;
  localparam int TIMEOUT = 1023;
  localparam int AW = $clog2(MAX_LEN);
  localparam int LW = AW + 1;

  logic          clk;
  logic          rst;
  logic          byte_valid;
  logic [7:0]    byte_data;
  logic          frame_valid;
  logic          frame_ready;
  logic [LW-1:0] frame_len;
  logic [AW-1:0] rd_addr;
  logic [7:0]    rd_data;
  logic          err_pulse;
  logic [1:0]    err_code;
  logic          overrun;

  int checkCount = 0;
  int errorCount = 0;

  logic [7:0] stim[$];

  rx_frame_ctrl #(.MAX_LEN(MAX_LEN), .SYNC(8'hA5), .TIMEOUT(TIMEOUT)) dut (
    .clk         (clk),
    .rst         (rst),
    .byte_valid  (byte_valid),
    .byte_data   (byte_data),
    .frame_valid (frame_valid),
    .frame_ready (frame_ready),
    .frame_len   (frame_len),
    .rd_addr     (rd_addr),
    .rd_data     (rd_data),
    .err_pulse   (err_pulse),
    .err_code    (err_code),
    .overrun     (overrun)
  );

  // Free-running clock, 10 ns period
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Hard stop in case the run ever stalls
  initial begin
    #500000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog expired");
  end

  // Compare one observed value against its expected value
  task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checkCount++;
    if (obs !== exp) begin
      errorCount++;
      $display("[TB] FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // Drive the queued bytes on consecutive cycles; returns on the negedge after the last is sampled
  task automatic applyStimulus();
    while (stim.size() > 0) begin
      @(negedge clk);
      byte_valid = 1'b1;
      byte_data  = stim.pop_front();
    end
    @(negedge clk);
    byte_valid = 1'b0;
    byte_data  = 8'h00;
  endtask

  // Read one buffer location and compare it
  task automatic checkRead(input string tag, input int addr, input logic [7:0] exp);
    rd_addr = AW'(addr);
    #1;
    checkOutput(tag, {24'b0, rd_data}, {24'b0, exp});
  endtask

  // Accept the held frame, optionally with a coincident byte
  task automatic acceptFrame(input logic withByte, input logic [7:0] b);
    @(negedge clk);
    frame_ready = 1'b1;
    byte_valid  = withByte;
    byte_data   = b;
    @(negedge clk);
    frame_ready = 1'b0;
    byte_valid  = 1'b0;
    byte_data   = 8'h00;
  endtask

  initial begin
    rst         = 1'b0;
    byte_valid  = 1'b0;
    byte_data   = 8'h00;
    frame_ready = 1'b0;
    rd_addr     = '0;

    repeat (3) @(negedge clk);
    checkOutput("reset frame_valid", {31'b0, frame_valid}, 0);
    checkOutput("reset frame_len", {27'b0, frame_len}, 0);
    checkOutput("reset err_pulse", {31'b0, err_pulse}, 0);
    checkOutput("reset err_code", {30'b0, err_code}, 0);
    checkOutput("reset overrun", {31'b0, overrun}, 0);
    rst = 1'b1;
    @(negedge clk);

    // Good frame: checksum 03^11^22^33 = 03
    stim = {8'hA5, 8'h03, 8'h11, 8'h22, 8'h33, 8'h03};
    applyStimulus();
    checkOutput("good err_pulse", {31'b0, err_pulse}, 0);
    @(negedge clk);
    checkOutput("good frame_valid", {31'b0, frame_valid}, 1);
    checkOutput("good frame_len", {27'b0, frame_len}, 3);
    checkRead("good rd0", 0, 8'h11);
    checkRead("good rd1", 1, 8'h22);
    checkRead("good rd2", 2, 8'h33);
    repeat (3) @(negedge clk);
    checkOutput("good held", {31'b0, frame_valid}, 1);
    acceptFrame(1'b0, 8'h00);
    checkOutput("good accepted", {31'b0, frame_valid}, 0);

    // Bad checksum: expected 02^10^20 = 32, sent 00; frame_ready high but ignored
    frame_ready = 1'b1;
    stim = {8'hA5, 8'h02, 8'h10, 8'h20, 8'h00};
    applyStimulus();
    frame_ready = 1'b0;
    checkOutput("badchk err_pulse", {31'b0, err_pulse}, 1);
    checkOutput("badchk err_code", {30'b0, err_code}, 2);
    @(negedge clk);
    checkOutput("badchk pulse width", {31'b0, err_pulse}, 0);
    checkOutput("badchk frame_valid", {31'b0, frame_valid}, 0);

    // Next good frame after the checksum error
    stim = {8'hA5, 8'h03, 8'h11, 8'h22, 8'h33, 8'h03};
    applyStimulus();
    @(negedge clk);
    checkOutput("recover frame_valid", {31'b0, frame_valid}, 1);
    checkRead("recover rd1", 1, 8'h22);
    acceptFrame(1'b0, 8'h00);

    // Length 17 > 16, then trailing bytes must be ignored
    stim = {8'hA5, 8'h11};
    applyStimulus();
    checkOutput("lenerr err_pulse", {31'b0, err_pulse}, 1);
    checkOutput("lenerr err_code", {30'b0, err_code}, 1);
    stim = {8'h01, 8'h44, 8'h45, 8'h00};
    applyStimulus();
    repeat (2) @(negedge clk);
    checkOutput("lenerr ignored valid", {31'b0, frame_valid}, 0);
    checkOutput("lenerr ignored err", {31'b0, err_pulse}, 0);

    // Maximum length 16 is allowed: payload 00..0F, checksum 10 ^ (XOR of 0..F = 0) = 10
    stim = {8'hA5, 8'h10};
    for (int i = 0; i < 16; i++) stim.push_back(8'(i));
    stim.push_back(8'h10);
    applyStimulus();
    checkOutput("maxlen err_pulse", {31'b0, err_pulse}, 0);
    @(negedge clk);
    checkOutput("maxlen frame_valid", {31'b0, frame_valid}, 1);
    checkOutput("maxlen frame_len", {27'b0, frame_len}, 16);
    checkRead("maxlen rd15", 15, 8'h0F);
    acceptFrame(1'b0, 8'h00);

    // Zero-length frame
    stim = {8'hA5, 8'h00, 8'h00};
    applyStimulus();
    @(negedge clk);
    checkOutput("zero frame_valid", {31'b0, frame_valid}, 1);
    checkOutput("zero frame_len", {27'b0, frame_len}, 0);
    acceptFrame(1'b0, 8'h00);

    // Timeout mid-payload: error after exactly TIMEOUT idle cycles
    stim = {8'hA5, 8'h02, 8'h55};
    applyStimulus();
    for (int i = 1; i <= TIMEOUT; i++) begin
      @(negedge clk);
      if (i == TIMEOUT - 1) checkOutput("tmo early", {31'b0, err_pulse}, 0);
      if (i == TIMEOUT) begin
        checkOutput("tmo err_pulse", {31'b0, err_pulse}, 1);
        checkOutput("tmo err_code", {30'b0, err_code}, 3);
      end
    end
    stim = {8'hA5, 8'h01, 8'h5A, 8'h5B};
    applyStimulus();
    @(negedge clk);
    checkOutput("tmo recover valid", {31'b0, frame_valid}, 1);
    acceptFrame(1'b0, 8'h00);

    // Backpressure and overrun: checksum 02^AB^CD = 64
    stim = {8'hA5, 8'h02, 8'hAB, 8'hCD, 8'h64};
    applyStimulus();
    @(negedge clk);
    checkOutput("bp frame_valid", {31'b0, frame_valid}, 1);
    checkOutput("bp overrun before", {31'b0, overrun}, 0);
    stim = {8'hFF, 8'hA5, 8'h12};
    applyStimulus();
    checkOutput("bp overrun", {31'b0, overrun}, 1);
    checkOutput("bp still valid", {31'b0, frame_valid}, 1);
    checkOutput("bp frame_len", {27'b0, frame_len}, 2);
    checkRead("bp rd0", 0, 8'hAB);
    checkRead("bp rd1", 1, 8'hCD);
    acceptFrame(1'b1, 8'hA5);
    checkOutput("bp accepted", {31'b0, frame_valid}, 0);
    checkOutput("bp overrun cleared", {31'b0, overrun}, 0);
    // If the accept-cycle A5 had been taken, this would complete a frame (01^77=76)
    stim = {8'h01, 8'h77, 8'h76};
    applyStimulus();
    repeat (2) @(negedge clk);
    checkOutput("accept byte dropped", {31'b0, frame_valid}, 0);
    checkOutput("accept byte no err", {31'b0, err_pulse}, 0);

    // Reset mid-payload
    stim = {8'hA5, 8'h04, 8'h01, 8'h02};
    applyStimulus();
    rst = 1'b0;
    #1;
    checkOutput("midrst frame_len", {27'b0, frame_len}, 0);
    checkOutput("midrst err_pulse", {31'b0, err_pulse}, 0);
    checkOutput("midrst frame_valid", {31'b0, frame_valid}, 0);
    repeat (2) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    checkOutput("midrst after release", {31'b0, err_pulse}, 0);
    stim = {8'hA5, 8'h01, 8'h5A, 8'h5B};
    applyStimulus();
    checkOutput("postrst no err", {31'b0, err_pulse}, 0);
    @(negedge clk);
    checkOutput("postrst frame_valid", {31'b0, frame_valid}, 1);
    checkOutput("postrst frame_len", {27'b0, frame_len}, 1);
    checkRead("postrst rd0", 0, 8'h5A);
    acceptFrame(1'b0, 8'h00);

    $display("CHECKS %0d ERRORS %0d", checkCount, errorCount);
    $finish;
  end

endmodule
